tlb_cmd_unit: RTL
=================

# tlb_cmd_unit

Sequencer for LoongArch TLB management instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) between the writeback-stage CSR file and the `tlb` array. It accepts one command, drives the array's write, read, search-port-1 and invalidate pins for exactly one cycle, and returns a one-cycle CSR update response. TLBFILL slot selection comes from an internal free-running pointer.

## Interface
- `TLBNUM`, default 16: number of TLB entries. `IDXW = $clog2(TLBNUM)`.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_op` in 3: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5–7 reserved.
- `cmd_inv_op` in 5, `cmd_inv_asid` in 10, `cmd_inv_vppn` in 19: INVTLB operands.
- `csr_tlbidx` in 32: index in [IDXW-1:0], PS in [29:24], NE in [31].
- `csr_tlbehi` in 32: VPPN in [31:13].
- `csr_tlbelo0`, `csr_tlbelo1` in 32: V[0], D[1], PLV[3:2], MAT[5:4], G[6], PPN[27:8].
- `csr_asid` in 10: current ASID.
- `csr_ecode_tlbr` in 1: ESTAT.Ecode == 0x3F (refill in progress).
- `s_vppn` out 19, `s_va_bit12` out 1, `s_asid` out 10: drive tlb search port 1.
- `s_found` in 1, `s_index` in IDXW: tlb search port 1 results.
- `invtlb_valid` out 1, `invtlb_op` out 5.
- `we` out 1, `w_index` out IDXW, `w_e`, `w_vppn`, `w_ps`, `w_asid`, `w_g`, `w_ppn0/1`, `w_plv0/1`, `w_mat0/1`, `w_d0/1`, `w_v0/1` out: tlb write port, widths as the array.
- `r_index` out IDXW; `r_e`, `r_vppn`, `r_ps`, `r_asid`, `r_g`, `r_ppn0/1`, `r_plv0/1`, `r_mat0/1`, `r_d0/1`, `r_v0/1` in: tlb read port.
- `resp_valid` out 1: one-cycle pulse; CSR file must accept it, with no backpressure.
- `resp_wmask` out 4: write enables for {asid, elo0+elo1, ehi, idx}, MSB first.
- `resp_tlbidx`, `resp_tlbehi`, `resp_tlbelo0`, `resp_tlbelo1` out 32; `resp_asid` out 10.
- `resp_err` out 1: reserved `cmd_op`, or INV with `inv_op` > 6.

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE.
  - `cmd_ready` = 1 only in IDLE.
  - A handshake latches `cmd_op`, the inv operands and all `csr_*` inputs, plus `fill_ptr`.
- `fill_ptr` (IDXW bits) increments every cycle from reset, wrapping TLBNUM-1 → 0. Reset value 0.
- EXEC, by op:
  - SRCH: `s_vppn` = latched ehi VPPN, `s_asid` = latched asid, `s_va_bit12` = 0. `s_found`/`s_index` are registered at the end of EXEC.
  - RD: `r_index` = latched idx index; all `r_*` fields are registered.
  - WR/FILL: `we` = 1.
    - `w_index` = idx index (WR) or latched `fill_ptr` (FILL).
    - `w_e` = `csr_ecode_tlbr` ? 1 : ~NE.
    - `w_asid` = latched asid. `w_g` = elo0.G & elo1.G.
    - Remaining fields are taken from the latched CSRs.
  - INV: `invtlb_valid` = 1, `invtlb_op` = inv_op, `s_asid` = inv_asid, `s_vppn` = inv_vppn.
    - If inv_op > 6, `invtlb_valid` stays 0.
- RESP (`resp_valid` = 1):
  - SRCH: `resp_wmask` = 0001. `resp_tlbidx` = {~found, latched bits [30:0] with the index field replaced by `s_index` when found}.
  - RD, `r_e` = 1: `resp_wmask` = 1111. idx = {NE=0, PS=`r_ps`, index kept}; ehi VPPN = `r_vppn`; elo built from the r fields with G = `r_g`; asid = `r_asid`.
  - RD, `r_e` = 0: `resp_wmask` = 1111. idx = {NE=1, PS=0, index kept}; ehi, elo0, elo1 and asid are all 0.
  - WR, FILL, INV, reserved: `resp_wmask` = 0000.
- Outside EXEC, `we`, `invtlb_valid` and all `s_*`/`w_*`/`r_index` outputs are 0.

## Timing
- Handshake in cycle T → EXEC at T+1 → `resp_valid` at T+2 → `cmd_ready` again at T+3. Throughput: 1 command per 3 cycles.
- The array write and invalidate take effect at the T+1→T+2 clock edge. A SRCH issued right after a WR therefore sees the new entry.
- CSR inputs are sampled only at the handshake. Later CSR changes do not affect an in-flight command.
- Reset values:
  - State IDLE, `cmd_ready` = 1.
  - `fill_ptr` = 0.
  - All other outputs 0.
- Asserting `resetn` mid-command immediately drops `we`, `invtlb_valid` and `resp_valid`. No response is issued for that command.

## Structure
- Shared package `tlb_cmd_pkg` holds:
  - op encodings;
  - the INVTLB op limit (6);
  - CSR field bit positions (TLBIDX, TLBEHI, TLBELO);
  - FSM state enum.
- Flat module, no sub-modules. `fill_ptr` is an inline counter.

## Test plan
- WR with idx=5, ehi VPPN=0x12345, asid=0x2A, PS=12, NE=0, elo0.PPN=0x00ABC, V=1 → `we` high for exactly 1 cycle at T+1 with `w_index`=5, `w_e`=1, `w_ps`=12; `resp_wmask`=0000 at T+2.
- After that WR, SRCH with the same VPPN/asid → `resp_tlbidx`[31]=0 and index=5. SRCH with VPPN 0x12346 → NE=1 and index unchanged.
- RD of index 5 → `resp_wmask`=1111, ehi=0x12345<<13, elo0.PPN=0x00ABC, asid=0x2A. RD of an empty index 9 → NE=1, PS=0, ehi/elo/asid = 0.
- FILL accepted when `fill_ptr`=15 → `w_index`=15; FILL with NE=1 and `csr_ecode_tlbr`=1 → `w_e`=1.
- INV op 5 with asid=0x2A, vppn=0x12345 → `invtlb_valid` for 1 cycle; a subsequent SRCH gives NE=1. INV op 7 → no `invtlb_valid`, `resp_err`=1.
- `resetn` low during EXEC of a WR → `we` drops at once, no `resp_valid`; `cmd_ready`=1 and `fill_ptr`=0 after release.

Source files
------------

// File: rtl/tlb_cmd_pkg.sv
// rtl/tlb_cmd_pkg.sv - shared encodings, CSR field positions and FSM states for tlb_cmd_unit
package tlb_cmd_pkg;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   localparam logic [4:0] INV_OP_MAX = 5'd6;

   localparam int IDX_NE      = 31;
   localparam int IDX_PS_MSB  = 29;
   localparam int IDX_PS_LSB  = 24;
   localparam int EHI_VPPN_LSB = 13;

   localparam int ELO_V       = 0;
   localparam int ELO_D       = 1;
   localparam int ELO_PLV_LSB = 2;
   localparam int ELO_MAT_LSB = 4;
   localparam int ELO_G       = 6;
   localparam int ELO_PPN_LSB = 8;
   localparam int ELO_PPN_MSB = 27;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

   function automatic logic [31:0] build_elo(input logic [19:0] ppn, input logic g,
                                              input logic [1:0] mat, input logic [1:0] plv,
                                              input logic d, input logic v);
      return {4'b0, ppn, 1'b0, g, mat, plv, d, v};
   endfunction

endpackage

// File: rtl/tlb_cmd_unit.sv
// rtl/tlb_cmd_unit.sv - sequences one TLB management command per 3 cycles between the CSR file and the tlb array
module tlb_cmd_unit
   import tlb_cmd_pkg::*;
#(
   parameter int TLBNUM = 16,
   localparam int IDXW = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      cmd_op,
   input  logic [4:0]      cmd_inv_op,
   input  logic [9:0]      cmd_inv_asid,
   input  logic [18:0]     cmd_inv_vppn,
   input  logic [31:0]     csr_tlbidx,
   input  logic [31:0]     csr_tlbehi,
   input  logic [31:0]     csr_tlbelo0,
   input  logic [31:0]     csr_tlbelo1,
   input  logic [9:0]      csr_asid,
   input  logic            csr_ecode_tlbr,
   output logic [18:0]     s_vppn,
   output logic            s_va_bit12,
   output logic [9:0]      s_asid,
   input  logic            s_found,
   input  logic [IDXW-1:0] s_index,
   output logic            invtlb_valid,
   output logic [4:0]      invtlb_op,
   output logic            we,
   output logic [IDXW-1:0] w_index,
   output logic            w_e,
   output logic [18:0]     w_vppn,
   output logic [5:0]      w_ps,
   output logic [9:0]      w_asid,
   output logic            w_g,
   output logic [19:0]     w_ppn0,
   output logic [1:0]      w_plv0,
   output logic [1:0]      w_mat0,
   output logic            w_d0,
   output logic            w_v0,
   output logic [19:0]     w_ppn1,
   output logic [1:0]      w_plv1,
   output logic [1:0]      w_mat1,
   output logic            w_d1,
   output logic            w_v1,
   output logic [IDXW-1:0] r_index,
   input  logic            r_e,
   input  logic [18:0]     r_vppn,
   input  logic [5:0]      r_ps,
   input  logic [9:0]      r_asid,
   input  logic            r_g,
   input  logic [19:0]     r_ppn0,
   input  logic [1:0]      r_plv0,
   input  logic [1:0]      r_mat0,
   input  logic            r_d0,
   input  logic            r_v0,
   input  logic [19:0]     r_ppn1,
   input  logic [1:0]      r_plv1,
   input  logic [1:0]      r_mat1,
   input  logic            r_d1,
   input  logic            r_v1,
   output logic            resp_valid,
   output logic [3:0]      resp_wmask,
   output logic [31:0]     resp_tlbidx,
   output logic [31:0]     resp_tlbehi,
   output logic [31:0]     resp_tlbelo0,
   output logic [31:0]     resp_tlbelo1,
   output logic [9:0]      resp_asid,
   output logic            resp_err
);

   state_t          state;
   logic [IDXW-1:0] fill_ptr;
   logic [2:0]      op_q;
   logic [30:0]     idx_q;
   logic            err_q;
   logic            cmd_err;
   logic            unused_ok;

   assign cmd_err = (cmd_op > OP_INV) || ((cmd_op == OP_INV) && (cmd_inv_op > INV_OP_MAX));
   assign unused_ok = ^{csr_tlbehi[EHI_VPPN_LSB-1:0], csr_tlbelo0[31:28], csr_tlbelo0[7],
                        csr_tlbelo1[31:28], csr_tlbelo1[7]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) fill_ptr <= '0;
      else if (fill_ptr == IDXW'(TLBNUM - 1)) fill_ptr <= '0;
      else fill_ptr <= fill_ptr + 1'b1;
   end

   // Array-side and response outputs default to 0 every cycle; they are only
   // loaded on the edge entering EXEC or RESP, so each is a one-cycle pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
         cmd_ready <= 1'b1;
         op_q <= '0; idx_q <= '0; err_q <= 1'b0;
         s_vppn <= '0; s_va_bit12 <= 1'b0; s_asid <= '0;
         invtlb_valid <= 1'b0; invtlb_op <= '0;
         we <= 1'b0; w_index <= '0; w_e <= 1'b0; w_vppn <= '0; w_ps <= '0; w_asid <= '0; w_g <= 1'b0;
         w_ppn0 <= '0; w_plv0 <= '0; w_mat0 <= '0; w_d0 <= 1'b0; w_v0 <= 1'b0;
         w_ppn1 <= '0; w_plv1 <= '0; w_mat1 <= '0; w_d1 <= 1'b0; w_v1 <= 1'b0;
         r_index <= '0;
         resp_valid <= 1'b0; resp_wmask <= '0; resp_tlbidx <= '0; resp_tlbehi <= '0;
         resp_tlbelo0 <= '0; resp_tlbelo1 <= '0; resp_asid <= '0; resp_err <= 1'b0;
      end else begin
         s_vppn <= '0; s_va_bit12 <= 1'b0; s_asid <= '0;
         invtlb_valid <= 1'b0; invtlb_op <= '0;
         we <= 1'b0; w_index <= '0; w_e <= 1'b0; w_vppn <= '0; w_ps <= '0; w_asid <= '0; w_g <= 1'b0;
         w_ppn0 <= '0; w_plv0 <= '0; w_mat0 <= '0; w_d0 <= 1'b0; w_v0 <= 1'b0;
         w_ppn1 <= '0; w_plv1 <= '0; w_mat1 <= '0; w_d1 <= 1'b0; w_v1 <= 1'b0;
         r_index <= '0;
         resp_valid <= 1'b0; resp_wmask <= '0; resp_tlbidx <= '0; resp_tlbehi <= '0;
         resp_tlbelo0 <= '0; resp_tlbelo1 <= '0; resp_asid <= '0; resp_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  state <= ST_EXEC;
                  cmd_ready <= 1'b0;
                  op_q <= cmd_op;
                  idx_q <= csr_tlbidx[30:0];
                  err_q <= cmd_err;
                  case (cmd_op)
                     OP_SRCH: begin
                        s_vppn <= csr_tlbehi[31:EHI_VPPN_LSB];
                        s_asid <= csr_asid;
                     end
                     OP_RD: r_index <= csr_tlbidx[IDXW-1:0];
                     OP_WR, OP_FILL: begin
                        we <= 1'b1;
                        w_index <= (cmd_op == OP_FILL) ? fill_ptr : csr_tlbidx[IDXW-1:0];
                        w_e <= csr_ecode_tlbr | ~csr_tlbidx[IDX_NE];
                        w_vppn <= csr_tlbehi[31:EHI_VPPN_LSB];
                        w_ps <= csr_tlbidx[IDX_PS_MSB:IDX_PS_LSB];
                        w_asid <= csr_asid;
                        w_g <= csr_tlbelo0[ELO_G] & csr_tlbelo1[ELO_G];
                        w_ppn0 <= csr_tlbelo0[ELO_PPN_MSB:ELO_PPN_LSB];
                        w_plv0 <= csr_tlbelo0[ELO_PLV_LSB+1:ELO_PLV_LSB];
                        w_mat0 <= csr_tlbelo0[ELO_MAT_LSB+1:ELO_MAT_LSB];
                        w_d0 <= csr_tlbelo0[ELO_D];
                        w_v0 <= csr_tlbelo0[ELO_V];
                        w_ppn1 <= csr_tlbelo1[ELO_PPN_MSB:ELO_PPN_LSB];
                        w_plv1 <= csr_tlbelo1[ELO_PLV_LSB+1:ELO_PLV_LSB];
                        w_mat1 <= csr_tlbelo1[ELO_MAT_LSB+1:ELO_MAT_LSB];
                        w_d1 <= csr_tlbelo1[ELO_D];
                        w_v1 <= csr_tlbelo1[ELO_V];
                     end
                     OP_INV: begin
                        invtlb_valid <= (cmd_inv_op <= INV_OP_MAX);
                        invtlb_op <= cmd_inv_op;
                        s_asid <= cmd_inv_asid;
                        s_vppn <= cmd_inv_vppn;
                     end
                     default: ;
                  endcase
               end
            end
            ST_EXEC: begin
               state <= ST_RESP;
               resp_valid <= 1'b1;
               resp_err <= err_q;
               case (op_q)
                  OP_SRCH: begin
                     resp_wmask <= 4'b0001;
                     resp_tlbidx <= {~s_found, idx_q};
                     if (s_found) resp_tlbidx[IDXW-1:0] <= s_index;
                  end
                  OP_RD: begin
                     resp_wmask <= 4'b1111;
                     if (r_e) begin
                        resp_tlbidx <= {1'b0, idx_q[30], r_ps, idx_q[23:0]};
                        resp_tlbehi <= {r_vppn, 13'b0};
                        resp_tlbelo0 <= build_elo(r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0);
                        resp_tlbelo1 <= build_elo(r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1);
                        resp_asid <= r_asid;
                     end else begin
                        resp_tlbidx <= {1'b1, idx_q[30], 6'b0, idx_q[23:0]};
                     end
                  end
                  default: ;
               endcase
            end
            ST_RESP: begin
               state <= ST_IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
